// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers for the raster generator.
// Defaults describe the standard 640x480@60 mode.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam logic POL_ACTIVE_LOW  = 1'b0;
  localparam logic POL_ACTIVE_HIGH = 1'b1;

  function automatic int axisTotal(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int syncStart(int active, int fp);
    return active + fp;
  endfunction

  function automatic int syncStop(int active, int fp, int sync);
    return active + fp + sync;
  endfunction

endpackage

// File: rtl/vga_timing_axis.sv
// One raster axis: wrapping position counter plus sync and active-area decode
// of the current (pre-increment) count.
module vga_timing_axis
  import vga_pkg::*;
#(
  parameter int   ACTIVE   = H_ACTIVE_DEF,
  parameter int   FP       = H_FP_DEF,
  parameter int   SYNC     = H_SYNC_DEF,
  parameter int   BP       = H_BP_DEF,
  parameter logic SYNC_POL = POL_ACTIVE_LOW,
  parameter int   W        = $clog2(axisTotal(ACTIVE, FP, SYNC, BP))
) (
  input  logic         iClock,
  input  logic         iReset,
  input  logic         iAdvance,
  output logic [W-1:0] oCount,
  output logic         oWrap,
  output logic         oSync,
  output logic         oActive
);

  localparam int TOTAL = axisTotal(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  // One extra bit so bounds equal to TOTAL stay representable
  localparam logic [W:0] SYNC_LO  = (W+1)'(syncStart(ACTIVE, FP));
  localparam logic [W:0] SYNC_HI  = (W+1)'(syncStop(ACTIVE, FP, SYNC));
  localparam logic [W:0] ACT_END  = (W+1)'(ACTIVE);

  logic [W:0] countWide;
  logic       syncOn;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      oCount <= '0;
    end else if (iAdvance) begin
      oCount <= oWrap ? '0 : oCount + 1'b1;
    end
  end

  assign countWide = {1'b0, oCount};
  assign oWrap     = (oCount == LAST);
  assign syncOn    = (countWide >= SYNC_LO) && (countWide < SYNC_HI);
  assign oSync     = syncOn ? SYNC_POL : ~SYNC_POL;
  assign oActive   = (countWide < ACT_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: H/V axes, scaled display window addressing and
// registered sync/strobe outputs, advanced by the iPixelEn pixel tick.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE    = H_ACTIVE_DEF,
  parameter int   H_FP        = H_FP_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BP        = H_BP_DEF,
  parameter int   V_ACTIVE    = V_ACTIVE_DEF,
  parameter int   V_FP        = V_FP_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BP        = V_BP_DEF,
  parameter logic H_SYNC_POL  = POL_ACTIVE_LOW,
  parameter logic V_SYNC_POL  = POL_ACTIVE_LOW,
  parameter int   WIN_X0      = 0,
  parameter int   WIN_Y0      = 0,
  parameter int   WIN_W       = 120,
  parameter int   WIN_H       = 120,
  parameter int   SCALE_SHIFT = 0,
  parameter int   X_WIDTH     = 7,
  parameter int   Y_WIDTH     = 7
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iPixelEn,
  output logic [X_WIDTH-1:0] oVideoMemCol,
  output logic [Y_WIDTH-1:0] oVideoMemRow,
  output logic               oVGAHorizontalSync,
  output logic               oVGAVerticalSync,
  output logic               oDisplay,
  output logic               oActive,
  output logic               oLineStart,
  output logic               oFrameStart
);

  localparam int H_W = $clog2(axisTotal(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int V_W = $clog2(axisTotal(V_ACTIVE, V_FP, V_SYNC, V_BP));

  if ((WIN_X0 + WIN_W > H_ACTIVE) || (WIN_Y0 + WIN_H > V_ACTIVE)) begin : gWinRangeErr
    $error("vga_timing_gen: window exceeds active area");
  end
  if ((((WIN_W - 1) >> SCALE_SHIFT) >= (1 << X_WIDTH)) ||
      (((WIN_H - 1) >> SCALE_SHIFT) >= (1 << Y_WIDTH))) begin : gAddrWidthErr
    $error("vga_timing_gen: scaled window does not fit address width");
  end

  logic [H_W-1:0] hCount;
  logic [V_W-1:0] vCount;
  logic           hWrap, vWrapUnused;
  logic           hSync, vSync, hActive, vActive;
  logic [H_W:0]   hRel;
  logic [V_W:0]   vRel;
  logic           inWindow;

  vga_timing_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .SYNC_POL(H_SYNC_POL), .W(H_W)
  ) uHAxis (
    .iClock(iClock), .iReset(iReset), .iAdvance(iPixelEn),
    .oCount(hCount), .oWrap(hWrap), .oSync(hSync), .oActive(hActive)
  );

  vga_timing_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .SYNC_POL(V_SYNC_POL), .W(V_W)
  ) uVAxis (
    .iClock(iClock), .iReset(iReset), .iAdvance(iPixelEn & hWrap),
    .oCount(vCount), .oWrap(vWrapUnused), .oSync(vSync), .oActive(vActive)
  );

  // Below the origin the offset borrows into the top bit, so one unsigned
  // compare against the window size covers both edges.
  assign hRel     = {1'b0, hCount} - (H_W+1)'(WIN_X0);
  assign vRel     = {1'b0, vCount} - (V_W+1)'(WIN_Y0);
  assign inWindow = hActive && vActive &&
                    (hRel < (H_W+1)'(WIN_W)) && (vRel < (V_W+1)'(WIN_H));

  always_ff @(posedge iClock) begin
    if (iReset) begin
      oVideoMemCol       <= '0;
      oVideoMemRow       <= '0;
      oVGAHorizontalSync <= ~H_SYNC_POL;
      oVGAVerticalSync   <= ~V_SYNC_POL;
      oDisplay           <= 1'b0;
      oActive            <= 1'b0;
      oLineStart         <= 1'b0;
      oFrameStart        <= 1'b0;
    end else if (iPixelEn) begin
      oVideoMemCol       <= inWindow ? X_WIDTH'(hRel[H_W-1:0] >> SCALE_SHIFT) : '0;
      oVideoMemRow       <= inWindow ? Y_WIDTH'(vRel[V_W-1:0] >> SCALE_SHIFT) : '0;
      oVGAHorizontalSync <= hSync;
      oVGAVerticalSync   <= vSync;
      oDisplay           <= inWindow;
      oActive            <= hActive && vActive;
      oLineStart         <= (hCount == '0);
      oFrameStart        <= (hCount == '0) && (vCount == '0);
    end else begin
      oLineStart         <= 1'b0;
      oFrameStart        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Checks three vga_timing_gen configurations against an arithmetic raster
// model (pixel index -> expected outputs), plus hand-computed anchor points.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp;
    bit hpol, vpol;
    int x0, y0, winW, winH, sh, xw, yw;
  } cfg_t;

  typedef struct packed {
    logic [15:0] col;
    logic [15:0] row;
    logic hs, vs, disp, act, ls, fs;
  } obs_t;

  localparam cfg_t CFG0 = '{640,16,96,48, 480,10,2,33, 1'b0,1'b0, 0,0,120,120, 0,7,7};
  localparam cfg_t CFG1 = '{32,4,6,6, 20,2,3,3, 1'b1,1'b1, 4,2,24,16, 2,3,2};
  localparam cfg_t CFG2 = '{640,16,96,48, 480,10,2,33, 1'b0,1'b0, 80,0,480,480, 2,7,7};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  always #5 clk = ~clk;

  logic [6:0] col0, row0, col2, row2;
  logic [2:0] col1;
  logic [1:0] row1;
  logic hs0, vs0, disp0, act0, ls0, fs0;
  logic hs1, vs1, disp1, act1, ls1, fs1;
  logic hs2, vs2, disp2, act2, ls2, fs2;

  vga_timing_gen u0 (
    .iClock(clk), .iReset(rst), .iPixelEn(en),
    .oVideoMemCol(col0), .oVideoMemRow(row0),
    .oVGAHorizontalSync(hs0), .oVGAVerticalSync(vs0),
    .oDisplay(disp0), .oActive(act0), .oLineStart(ls0), .oFrameStart(fs0)
  );

  vga_timing_gen #(
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
    .WIN_X0(4), .WIN_Y0(2), .WIN_W(24), .WIN_H(16),
    .SCALE_SHIFT(2), .X_WIDTH(3), .Y_WIDTH(2)
  ) u1 (
    .iClock(clk), .iReset(rst), .iPixelEn(en),
    .oVideoMemCol(col1), .oVideoMemRow(row1),
    .oVGAHorizontalSync(hs1), .oVGAVerticalSync(vs1),
    .oDisplay(disp1), .oActive(act1), .oLineStart(ls1), .oFrameStart(fs1)
  );

  vga_timing_gen #(
    .WIN_X0(80), .WIN_Y0(0), .WIN_W(480), .WIN_H(480),
    .SCALE_SHIFT(2), .X_WIDTH(7), .Y_WIDTH(7)
  ) u2 (
    .iClock(clk), .iReset(rst), .iPixelEn(en),
    .oVideoMemCol(col2), .oVideoMemRow(row2),
    .oVGAHorizontalSync(hs2), .oVGAVerticalSync(vs2),
    .oDisplay(disp2), .oActive(act2), .oLineStart(ls2), .oFrameStart(fs2)
  );

  int vecs = 0;
  int errs = 0;

  // Output expected for raster pixel number idx (counted from reset).
  function automatic obs_t model(cfg_t c, bit have, int idx, bit strobe);
    obs_t o;
    int ht, vt, h, v, hsLo, vsLo;
    o = '0;
    if (!have) begin
      o.hs = !c.hpol;
      o.vs = !c.vpol;
      return o;
    end
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    h = idx % ht;
    v = (idx / ht) % vt;
    hsLo = c.ha + c.hfp;
    vsLo = c.va + c.vfp;
    o.hs  = (h >= hsLo && h < hsLo + c.hs) ? c.hpol : !c.hpol;
    o.vs  = (v >= vsLo && v < vsLo + c.vs) ? c.vpol : !c.vpol;
    o.act = (h < c.ha) && (v < c.va);
    o.disp = o.act && h >= c.x0 && h < c.x0 + c.winW && v >= c.y0 && v < c.y0 + c.winH;
    if (o.disp) begin
      o.col = 16'(((h - c.x0) >> c.sh) & ((1 << c.xw) - 1));
      o.row = 16'(((v - c.y0) >> c.sh) & ((1 << c.yw) - 1));
    end
    o.ls = strobe && (h == 0);
    o.fs = strobe && (h == 0) && (v == 0);
    return o;
  endfunction

  task automatic chk(string nm, int idx, obs_t got, obs_t want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s idx=%0d got col=%0d row=%0d hs=%b vs=%b disp=%b act=%b ls=%b fs=%b want col=%0d row=%0d hs=%b vs=%b disp=%b act=%b ls=%b fs=%b",
               nm, idx, got.col, got.row, got.hs, got.vs, got.disp, got.act, got.ls, got.fs,
               want.col, want.row, want.hs, want.vs, want.disp, want.act, want.ls, want.fs);
    end
  endtask

  task automatic chkVal(string nm, int got, int want);
    vecs++;
    if (got != want) begin
      errs++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Model state: n = enabled ticks since reset, idx = pixel on the outputs.
  int  n = 0, idx = 0, cyc = 0;
  bit  have = 0, strobe = 0, rS, eS;
  int  phase = 0;
  int  lastLs = -1, lastLsPh = -1, lastFs = -1, lastFsPh = -1;
  obs_t g0, g1, g2;

  always @(posedge clk) begin
    rS = rst;
    eS = en;
    cyc++;
    if (rS) begin
      n = 0; have = 0; strobe = 0;
      lastLs = -1; lastFs = -1;
    end else if (eS) begin
      idx = n; n++; have = 1; strobe = 1;
    end else begin
      strobe = 0;
    end
    #1;
    g0 = '{16'(col0), 16'(row0), hs0, vs0, disp0, act0, ls0, fs0};
    g1 = '{16'(col1), 16'(row1), hs1, vs1, disp1, act1, ls1, fs1};
    g2 = '{16'(col2), 16'(row2), hs2, vs2, disp2, act2, ls2, fs2};
    chk("u0_model", idx, g0, model(CFG0, have, idx, strobe));
    chk("u1_model", idx, g1, model(CFG1, have, idx, strobe));
    chk("u2_model", idx, g2, model(CFG2, have, idx, strobe));

    if (rS) begin
      chkVal("reset_u0_syncs_idle_high", int'({hs0, vs0}), 3);
      chkVal("reset_u1_syncs_idle_low", int'({hs1, vs1}), 0);
      chkVal("reset_u0_strobes", int'({ls0, fs0, disp0, act0}), 0);
    end
    if (strobe) begin
      case (idx)
        0:    chkVal("first_tick_framestart", int'({fs0, fs1, fs2}), 7);
        655:  chkVal("h655_hsync_idle", int'(hs0), 1);
        656:  chkVal("h656_hsync_active", int'(hs0), 0);
        751:  chkVal("h751_hsync_active", int'(hs0), 0);
        752:  chkVal("h752_hsync_idle", int'(hs0), 1);
        800:  chkVal("line1_start_nonframe", int'({ls0, fs0}), 2);
        4119: chkVal("win_119_5", int'({disp0, col0, row0}), (1 << 14) | (119 << 7) | 5);
        4120: chkVal("win_120_5_outside", int'({disp0, col0, row0}), 0);
        1056: chkVal("u1_vsync_line22_active_high", int'({vs1, hs1}), 2);
        5679: chkVal("u2_79_7_outside", int'(disp2), 0);
        5683: chkVal("u2_83_7_scaled", int'({disp2, col2, row2}), (1 << 14) | (0 << 7) | 1);
        default: ;
      endcase
    end

    // Strobe spacing in clocks: 800/1344 continuous, doubled when ticking every other clock
    if (ls0) begin
      if (lastLs >= 0 && lastLsPh == phase && phase != 0)
        chkVal("u0_linestart_period", cyc - lastLs, (phase == 1) ? 800 : 1600);
      lastLs = cyc; lastLsPh = phase;
    end
    if (fs1) begin
      if (lastFs >= 0 && lastFsPh == phase && phase != 0)
        chkVal("u1_framestart_period", cyc - lastFs, (phase == 1) ? 1344 : 2688);
      lastFs = cyc; lastFsPh = phase;
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; phase = 1;
    repeat (6000) @(negedge clk);
    phase = 2;
    for (int i = 0; i < 3000; i++) begin
      en = (i % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    phase = 0;
    rst = 1'b1; en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1; phase = 1;
    repeat (1500) @(negedge clk);
    phase = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; phase = 1;
    repeat (500) @(negedge clk);
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
